// File: rtl/ped_pkg.sv
// Shared types and default sizes for the pedestrian request path.
// States and build-time constants used by ped_request_latch and btn_debounce.
package ped_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVING = 2'd2,
        LOCKOUT = 2'd3
    } ped_state_t;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: synchroniser chain, stability debouncer, rising-edge pulse.
// press is high for one cycle each time the debounced level goes 0 -> 1.
module btn_debounce
    import ped_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    logic [CW-1:0]          cnt;
    logic                   deb;
    logic                   deb_d;

    assign sync_q = sync_ff[SYNC_STAGES-1];

    // Metastability chain on the asynchronous button input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], button_raw};
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            deb   <= 1'b0;
            deb_d <= 1'b0;
        end else begin
            deb_d <= deb;
            if (sync_q == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                deb <= ~deb;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = deb & ~deb_d;

endmodule

// File: rtl/ped_request_latch.sv
// Pedestrian request latch: holds a level request until the controller serves it.
// Optional post-service lockout window enabled by defining PED_LOCKOUT_EN.
module ped_request_latch
    import ped_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int LOCKOUT_CYCLES  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button_raw,
    input  logic             ack,
    output logic             request,
    output logic             pending,
    output logic [CNT_W-1:0] press_count
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_param
        $error("ped_request_latch: illegal parameter value");
    end

    ped_state_t       state_q;
    ped_state_t       state_d;
    logic             press;
    logic             accept;
    logic             request_q;
    logic [CNT_W-1:0] count_q;

`ifdef PED_LOCKOUT_EN
    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);
    logic [LOCK_W-1:0] lock_q;
    logic [LOCK_W-1:0] lock_d;
`endif

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .button_raw(button_raw),
        .press     (press)
    );

    // Next-state logic; a press is only taken from IDLE, ack wins in PENDING.
    always_comb begin
        state_d = state_q;
`ifdef PED_LOCKOUT_EN
        lock_d  = lock_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (press) state_d = PENDING;
            end
            PENDING: begin
                if (ack) state_d = SERVING;
            end
            SERVING: begin
                if (!ack) begin
`ifdef PED_LOCKOUT_EN
                    state_d = LOCKOUT;
                    lock_d  = LOCK_LOAD;
`else
                    state_d = IDLE;
`endif
                end
            end
            LOCKOUT: begin
`ifdef PED_LOCKOUT_EN
                if (lock_q == '0) begin
                    state_d = IDLE;
                end else begin
                    lock_d = lock_q - LOCK_W'(1);
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = (state_q == IDLE) && press;

    // State, registered request and saturating accepted-press counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            request_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            request_q <= (state_d == PENDING);
            if (accept && count_q != {CNT_W{1'b1}}) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

`ifdef PED_LOCKOUT_EN
    // Lockout down-counter, only meaningful while in LOCKOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= '0;
        end else begin
            lock_q <= lock_d;
        end
    end
`endif

    assign request     = request_q;
    assign pending     = request_q;
    assign press_count = count_q;

endmodule
